sad_min_select: RTL and testbench

- Consumer end of the motion-estimation pixel stream produced by the search controller.
- After a `start` pulse, takes one current pixel `c` and two candidate reference pixels `p` and `p_prime` per valid cycle.
- Accumulates the sum of absolute differences (SAD) for the two candidates over each block.
- Tracks the minimum SAD across all candidate pairs and reports the best SAD and candidate index with a one-cycle `done` pulse.

---
 rtl/me_pkg.sv | 23 ++
 rtl/sad_min_select_if.sv | 30 +++
 rtl/absdiff_acc.sv | 44 ++++
 rtl/sad_min_select.sv | 154 +++++++++++++++
 tb/tb_sad_min_select.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// Shared types and sizing helpers for the motion-estimation SAD search blocks.
package me_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StFlush,
        StDone
    } state_e;

    localparam int unsigned PixWDef     = 8;
    localparam int unsigned BlkPixDef   = 16;
    localparam int unsigned NumPairsDef = 256;

    function automatic int unsigned sad_w(input int unsigned pix_w, input int unsigned blk_pix);
        return pix_w + $clog2(blk_pix);
    endfunction

    function automatic int unsigned idx_w(input int unsigned num_pairs);
        return $clog2(2 * num_pairs);
    endfunction

endpackage

// File: rtl/sad_min_select_if.sv
// Pixel-stream input and search-result output bundle of sad_min_select.
interface sad_min_select_if
    import me_pkg::*;
#(
    parameter int unsigned PixW = PixWDef,
    parameter int unsigned SadW = sad_w(PixWDef, BlkPixDef),
    parameter int unsigned IdxW = idx_w(NumPairsDef)
) ();

    logic            start;
    logic            in_valid;
    logic [PixW-1:0] c;
    logic [PixW-1:0] p;
    logic [PixW-1:0] p_prime;
    logic [SadW-1:0] best_sad;
    logic [IdxW-1:0] best_idx;
    logic            done;
    logic            busy;

    modport master (
        output start, in_valid, c, p, p_prime,
        input  best_sad, best_idx, done, busy
    );

    modport slave (
        input  start, in_valid, c, p, p_prime,
        output best_sad, best_idx, done, busy
    );

endinterface

// File: rtl/absdiff_acc.sv
// Per-candidate |a-b| accumulator; sum_final already includes this cycle's difference
// so the block total can be latched on the last sample without an extra cycle.
module absdiff_acc #(
    parameter int unsigned PixW = 8,
    parameter int unsigned SadW = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PixW-1:0] a,
    input  logic [PixW-1:0] b,
    input  logic            valid,
    input  logic            clear,
    input  logic            last,
    output logic [SadW-1:0] sum_final,
    output logic [SadW-1:0] acc
);

    logic [PixW:0]   diff;
    logic [PixW-1:0] mag;
    logic [SadW-1:0] acc_q, acc_d;

    assign diff      = {1'b0, a} - {1'b0, b};
    assign mag       = diff[PixW] ? PixW'(-diff) : diff[PixW-1:0];
    assign sum_final = acc_q + SadW'(mag);
    assign acc       = acc_q;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (valid) begin
            acc_d = last ? '0 : sum_final;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sad_min_select.sv
// Accumulates SAD for candidate pairs 2k/2k+1 and tracks the minimum over a search;
// the compare of one block overlaps accumulation of the next.
module sad_min_select
    import me_pkg::*;
#(
    parameter int unsigned PixW     = PixWDef,
    parameter int unsigned BlkPix   = BlkPixDef,
    parameter int unsigned NumPairs = NumPairsDef
) (
    input logic            clk,
    input logic            reset,
    sad_min_select_if.slave bus
);

    localparam int unsigned SadW     = sad_w(PixW, BlkPix);
    localparam int unsigned IdxW     = idx_w(NumPairs);
    localparam int unsigned PixCntW  = $clog2(BlkPix);
    localparam int unsigned PairCntW = IdxW - 1;

    localparam logic [PixCntW-1:0]  PixLast  = PixCntW'(BlkPix - 1);
    localparam logic [PairCntW-1:0] PairLast = PairCntW'(NumPairs - 1);
    localparam logic [SadW-1:0]     SadMax   = '1;

    state_e              state_q;
    logic [PixCntW-1:0]  pix_cnt_q;
    logic [PairCntW-1:0] pair_cnt_q, cmp_pair_q;
    logic [SadW-1:0]     cmp0_q, cmp1_q, min_sad_q, best_sad_q;
    logic [IdxW-1:0]     min_idx_q, best_idx_q;
    logic                cmp_pend_q, done_q;

    logic            sample, blk_end, clear;
    logic [SadW-1:0] sum0, sum1, acc0, acc1;
    logic [SadW-1:0] t_sad, new_sad;
    logic [IdxW-1:0] t_idx, new_idx;
    logic            unused_acc;

    assign sample     = (state_q == StAccum) && bus.in_valid;
    assign blk_end    = sample && (pix_cnt_q == PixLast);
    assign clear      = (state_q == StIdle) && bus.start;
    assign unused_acc = ^{acc0, acc1};

    absdiff_acc #(.PixW(PixW), .SadW(SadW)) u_acc_even (
        .clk      (clk),
        .reset    (reset),
        .a        (bus.c),
        .b        (bus.p),
        .valid    (sample),
        .clear    (clear),
        .last     (blk_end),
        .sum_final(sum0),
        .acc      (acc0)
    );

    absdiff_acc #(.PixW(PixW), .SadW(SadW)) u_acc_odd (
        .clk      (clk),
        .reset    (reset),
        .a        (bus.c),
        .b        (bus.p_prime),
        .valid    (sample),
        .clear    (clear),
        .last     (blk_end),
        .sum_final(sum1),
        .acc      (acc1)
    );

    // Strict less-than: ties keep the lower index, even before odd.
    always_comb begin
        t_sad = min_sad_q;
        t_idx = min_idx_q;
        if (cmp0_q < min_sad_q) begin
            t_sad = cmp0_q;
            t_idx = {cmp_pair_q, 1'b0};
        end
        new_sad = t_sad;
        new_idx = t_idx;
        if (cmp1_q < t_sad) begin
            new_sad = cmp1_q;
            new_idx = {cmp_pair_q, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            pix_cnt_q  <= '0;
            pair_cnt_q <= '0;
            cmp_pair_q <= '0;
            cmp0_q     <= '0;
            cmp1_q     <= '0;
            cmp_pend_q <= 1'b0;
            min_sad_q  <= SadMax;
            min_idx_q  <= '0;
            best_sad_q <= '0;
            best_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q    <= StAccum;
                        pix_cnt_q  <= '0;
                        pair_cnt_q <= '0;
                        cmp_pend_q <= 1'b0;
                        min_sad_q  <= SadMax;
                        min_idx_q  <= '0;
                    end
                end
                StAccum: begin
                    if (cmp_pend_q) begin
                        min_sad_q  <= new_sad;
                        min_idx_q  <= new_idx;
                        cmp_pend_q <= 1'b0;
                    end
                    if (sample) begin
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                    end
                    // A block end in the same cycle as a compare re-arms cmp_pend.
                    if (blk_end) begin
                        cmp0_q     <= sum0;
                        cmp1_q     <= sum1;
                        cmp_pair_q <= pair_cnt_q;
                        cmp_pend_q <= 1'b1;
                        pair_cnt_q <= pair_cnt_q + 1'b1;
                        if (pair_cnt_q == PairLast) begin
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    min_sad_q  <= new_sad;
                    min_idx_q  <= new_idx;
                    best_sad_q <= new_sad;
                    best_idx_q <= new_idx;
                    cmp_pend_q <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.best_sad = best_sad_q;
    assign bus.best_idx = best_idx_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_sad_min_select.sv
// Directed bench for sad_min_select: the driver queues hand-computed results,
// a negedge monitor pops one per done pulse and checks value and timing.
module tb_sad_min_select;
    import me_pkg::*;

    localparam int unsigned PixW     = 8;
    localparam int unsigned BlkPix   = 16;
    localparam int unsigned NumPairs = 4;
    localparam int unsigned SadW     = sad_w(PixW, BlkPix);
    localparam int unsigned IdxW     = idx_w(NumPairs);
    localparam int          NumPix   = BlkPix * NumPairs;

    typedef struct {
        int sad;
        int idx;
        int cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   last_sad = 0;
    int   last_idx = 0;
    exp_t exp_q[$];

    sad_min_select_if #(.PixW(PixW), .SadW(SadW), .IdxW(IdxW)) bus ();

    sad_min_select #(.PixW(PixW), .BlkPix(BlkPix), .NumPairs(NumPairs)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_best_sad", int'(bus.best_sad), e.sad);
                check("sb_best_idx", int'(bus.best_idx), e.idx);
                check("sb_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic pix_vals(input int tid, input int pr,
                            output logic [7:0] cv, output logic [7:0] pv, output logic [7:0] qv);
        case (tid)
            0: begin cv = 8'h40; pv = 8'h40; qv = 8'h40; end
            1: begin cv = 8'h80; pv = 8'h70; qv = (pr == 2) ? 8'h7F : 8'h70; end
            2: begin cv = 8'h00; pv = 8'hFF; qv = (pr == 1) ? 8'hFE : 8'hFF; end
            3: begin cv = 8'hFF; pv = (pr == 3) ? 8'h02 : 8'h00; qv = 8'h01; end
            default: begin
                cv = 8'h10;
                pv = (pr == 3) ? 8'h18 : 8'h20;
                qv = (pr == 3) ? 8'h18 : ((pr == 1) ? 8'h19 : 8'h20);
            end
        endcase
    endtask

    task automatic run_search(input int tid, input bit gaps, input bit junk_start,
                              input int mid_start, input int exp_sad, input int exp_idx);
        logic [7:0] cv, pv, qv;
        int k;
        bus.start = 1'b1;
        // A sample alongside start must not be accumulated.
        if (junk_start) begin
            bus.in_valid = 1'b1;
            bus.c        = 8'h00;
            bus.p        = 8'hFF;
            bus.p_prime  = 8'hFF;
        end
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
        check("best_sad_held", int'(bus.best_sad), last_sad);
        check("best_idx_held", int'(bus.best_idx), last_idx);
        for (int i = 0; i < NumPix; i++) begin
            pix_vals(tid, i / BlkPix, cv, pv, qv);
            bus.in_valid = 1'b1;
            bus.c        = cv;
            bus.p        = pv;
            bus.p_prime  = qv;
            bus.start    = (i == mid_start);
            k = cyc;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
            // Sample presented during cycle k: FLUSH in k+1, done in k+2.
            if (i == NumPix - 1) begin
                exp_q.push_back('{sad: exp_sad, idx: exp_idx, cyc: k + 2});
            end else if (gaps) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
        for (int n = 0; n < 8 && bus.busy; n++) begin
            @(posedge clk); #1;
        end
        check("busy_cleared", int'(bus.busy), 0);
        check("best_sad_final", int'(bus.best_sad), exp_sad);
        check("best_idx_final", int'(bus.best_idx), exp_idx);
        last_sad = exp_sad;
        last_idx = exp_idx;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic abort_search();
        logic [7:0] cv, pv, qv;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            pix_vals(1, i / BlkPix, cv, pv, qv);
            bus.in_valid = 1'b1;
            bus.c        = cv;
            bus.p        = pv;
            bus.p_prime  = qv;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("busy_before_abort", int'(bus.busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_best_sad", int'(bus.best_sad), 0);
        check("abort_best_idx", int'(bus.best_idx), 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        last_sad = 0;
        last_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        check("post_abort_busy", int'(bus.busy), 0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.c        = '0;
        bus.p        = '0;
        bus.p_prime  = '0;

        for (int i = 0; i < 5; i++) begin
            bus.start    = 1'($urandom);
            bus.in_valid = 1'($urandom);
            bus.c        = 8'($urandom);
            bus.p        = 8'($urandom);
            bus.p_prime  = 8'($urandom);
            @(posedge clk); #1;
            check("rst_best_sad", int'(bus.best_sad), 0);
            check("rst_best_idx", int'(bus.best_idx), 0);
            check("rst_done", int'(bus.done), 0);
            check("rst_busy", int'(bus.busy), 0);
        end
        bus.start = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom);
            bus.c        = 8'($urandom);
            @(posedge clk); #1;
            check("idle_busy", int'(bus.busy), 0);
            check("idle_best_sad", int'(bus.best_sad), 0);
        end
        bus.in_valid = 1'b0;

        run_search(0, 1'b0, 1'b1, -1, 0, 0);
        run_search(1, 1'b0, 1'b0, -1, 16, 5);
        run_search(2, 1'b0, 1'b0, -1, 4064, 3);
        run_search(3, 1'b0, 1'b0, -1, 4048, 6);
        run_search(1, 1'b1, 1'b0, -1, 16, 5);
        run_search(4, 1'b0, 1'b0, -1, 128, 6);
        run_search(1, 1'b0, 1'b0, 20, 16, 5);
        abort_search();
        run_search(4, 1'b0, 1'b0, -1, 128, 6);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
